fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer for the RV32I pipeline. Owns the program counter and drives the address of the 256-word asynchronous-read instruction memory. Buffers fetched words in a small FIFO toward the IF/ID stage using a valid/ready handshake. Applies branch/JALR redirects from EX and traps misaligned or out-of-range fetches.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded at reset.
- `MEM_WORDS`, 256: instruction memory depth in 32-bit words. Legal PC range is 0 to 4*MEM_WORDS-4.
- `FIFO_DEPTH`, 2: fetch buffer entries (power of two, ≥2).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: leave IDLE and begin fetching.
- `imem_addr`  out  32: byte address to instruction memory. Always equals the PC register.
- `imem_rdata`  in  32: instruction word. Combinational from `imem_addr`, valid in the same cycle.
- `redirect_valid`  in  1: taken branch / JAL / JALR from EX.
- `redirect_pc`  in  32: redirect target.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: IF/ID accepts head.
- `out_pc`  out  32: PC of head entry.
- `out_instr`  out  32: instruction of head entry.
- `fault`  out  1: fetch fault state active.
- `fault_pc`  out  32: offending PC, captured on fault entry.

## Operation
- States: IDLE, RUN, FAULT.
  - IDLE → RUN when `start`=1.
  - RUN → FAULT on an illegal fetch PC.
  - FAULT → RUN on a legal redirect.
  - No other transitions. Only `rst` returns the block to IDLE.
- Legal PC: `pc[1:0]`==0 and `pc` < 4*MEM_WORDS (unsigned).
- Fetch (RUN only): fires when the PC is legal, there is no redirect, and the FIFO is not full or a pop occurs in the same cycle.
  - On fire: push {pc, imem_rdata}; pc ← pc+4. The adder wraps mod 2^32; overflow is irrelevant because the range check fails first.
- Illegal PC in RUN: no push. State ← FAULT; `fault_pc` ← pc. FIFO entries already fetched remain and drain normally.
- Redirect (RUN or FAULT): FIFO cleared; pc ← `redirect_pc`; any word read in that cycle is discarded.
  - In FAULT, a redirect to a legal target returns to RUN and clears `fault`. An illegal target keeps FAULT and updates `fault_pc` ← `redirect_pc`.
  - Redirects in IDLE are ignored.
- Pop: `out_valid && out_ready`.
- Redirect and pop in the same cycle: the pop counts as a completed transfer. Killing that instruction downstream is the pipeline's responsibility. The FIFO is then cleared.
- `out_valid`/`out_pc`/`out_instr` come straight from FIFO head registers. While `out_valid`=1 and `out_ready`=0, they are held stable.
- Reset values:
  - pc=RESET_PC; state=IDLE.
  - FIFO empty; entry storage zeroed.
  - `out_valid`=0, `out_pc`=0, `out_instr`=0.
  - `fault`=0, `fault_pc`=0.
  - `imem_addr`=RESET_PC.

## Timing
- `start` sampled at edge N: RUN from N. First fetch at edge N+1. `out_valid`=1 after N+1 with `out_pc`=RESET_PC.
- Steady state with `out_ready`=1: one instruction per cycle. Fetch-to-output latency is 1 edge.
- FIFO full and no pop: fetch stalls, pc holds. Fetch resumes in the same cycle as the releasing pop.
- Redirect at edge M: `out_valid`=0 after M. Target fetched at edge M+1 and presented after M+1. Redirect penalty is 1 bubble cycle.
- Fault entry at edge F: `fault`=1 after F. `out_valid` deasserts only once the FIFO drains.
- `rst` asserted mid-operation: all state clears immediately (asynchronous), regardless of handshake state.

## Structure
- Shared package `fetch_pkg`:
  - state enum (IDLE, RUN, FAULT);
  - `NOP_INSTR`=32'h0000_0013;
  - `XLEN`=32;
  - FIFO entry struct {pc, instr}.
- Sub-module `fetch_fifo`: parameterized FIFO_DEPTH buffer with synchronous clear, push/pop, full/empty, and head outputs taken from registers. The FSM, PC register and legality check stay in `fetch_controller`.

## Test plan
- Reset, `start` pulse, memory preloaded 0x00..0x0C, `out_ready`=1 → `out_pc` sequence 0x0,0x4,0x8,0xC on consecutive cycles, with `out_instr` matching memory.
- `out_ready`=0 for 5 cycles after start → exactly 2 entries (0x0, 0x4) buffered and `imem_addr`=0x8 held. On release, 0x0,0x4,0x8 are delivered with no gap and no duplicate.
- Redirect to 0x40 while PCs 0x18/0x1C are buffered → both flushed, one bubble, next `out_pc`=0x40. A simultaneous pop of 0x18 counts as transferred.
- Redirect to 0x42 → `fault`=1, `fault_pc`=0x42, no further pushes. A later redirect to 0x2C → `fault`=0, fetch resumes at 0x2C.
- Sequential run up to 0x3FC with MEM_WORDS=256 → 0x3FC delivered, then `fault`=1 with `fault_pc`=0x400.
- `rst` asserted mid-stream with 2 entries buffered → all outputs at reset values immediately. After `start`, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction-fetch slice.
// Provides the controller state enum, the FIFO entry struct, the
// machine word width, the canonical NOP encoding, and the PC legality
// helper used by both the sequencer and its redirect handling.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // A fetch address is usable only if it is word aligned and lies inside
  // the instruction memory. The limit is the first byte past the memory.
  function automatic logic pc_legal(input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if
// Bundles the fetch unit's bus-side signals.
//   imem_addr / imem_rdata      : asynchronous-read instruction memory port
//   redirect_valid / redirect_pc: control-flow redirect coming from EX
//   out_valid / out_ready       : handshake toward the IF/ID stage
//   out_pc / out_instr          : payload of the FIFO head entry
// The master modport is the fetch controller; slave is its environment.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small circular buffer of fetched {pc, instr} entries.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous flush, wins over push/pop
//   push     : write wdata at the tail (caller guarantees room)
//   pop      : retire the head entry (caller guarantees non-empty)
//   head     : current head entry, read straight from storage registers
//   empty    : no entries held
//   full     : DEPTH entries held
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    count;

  // Storage, pointers and occupancy. Reset zeroes the storage so the head
  // outputs read as zero until the first push. A clear only rewinds the
  // pointers; stale storage is never visible because empty gates validity.
  // Push and pop in the same cycle leave the occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// address, buffers fetched words toward IF/ID, applies redirects from EX
// and traps misaligned or out-of-range fetch addresses.
//   clk, rst : clock and asynchronous active-high reset
//   start    : leave IDLE and begin fetching
//   bus      : memory port, redirect input and IF/ID handshake (master side)
//   fault    : fetch fault state active
//   fault_pc : offending PC captured when the fault was raised or updated
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              MEM_WORDS  = 256,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  fetch_controller_if.master  bus,
  output logic                fault,
  output logic [XLEN-1:0]     fault_pc
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(4 * MEM_WORDS);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] fault_pc_next;
  logic            push, pop, clear;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    push_entry, head;

  assign pop        = !fifo_empty && bus.out_ready;
  assign push_entry = '{pc: pc, instr: bus.imem_rdata};

  // State, PC and fault address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      fault_pc <= fault_pc_next;
    end
  end

  // Next-state and fetch decisions. A redirect outranks everything else:
  // it flushes the buffer and throws away whatever word was read this
  // cycle. A redirect to a bad target while running is not trapped here;
  // the next cycle sees the illegal PC and raises the fault then, so
  // fault_pc still reports the redirect target. Fetch may fill the last
  // free slot or reuse the slot freed by a same-cycle pop.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    fault_pc_next = fault_pc;
    push          = 1'b0;
    clear         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          clear   = 1'b1;
          pc_next = bus.redirect_pc;
        end else if (!pc_legal(pc, PC_LIMIT)) begin
          state_next    = FAULT;
          fault_pc_next = pc;
        end else if (!fifo_full || pop) begin
          push    = 1'b1;
          pc_next = pc + 32'd4;
        end
      end
      FAULT: begin
        if (bus.redirect_valid) begin
          clear   = 1'b1;
          pc_next = bus.redirect_pc;
          if (pc_legal(bus.redirect_pc, PC_LIMIT)) begin
            state_next = RUN;
          end else begin
            fault_pc_next = bus.redirect_pc;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign fault         = (state == FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
// Scoreboard bench for fetch_controller. Stimulus queues the PCs it expects
// IF/ID to accept; a negedge monitor pops and compares on every transfer.
// Instruction memory word i holds 32'hC0DE_0000 + i.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        fault;
  logic [31:0] fault_pc;

  fetch_controller_if bus ();

  logic [31:0] imem [256];
  logic [31:0] expq [$];
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  assign bus.imem_rdata = imem[bus.imem_addr[9:2]];

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .MEM_WORDS  (256),
    .FIFO_DEPTH (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.master),
    .fault    (fault),
    .fault_pc (fault_pc)
  );

  function automatic logic [31:0] expInstr(input logic [31:0] pc);
    return 32'hC0DE_0000 + {2'b00, pc[31:2]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic rdy,
                               input logic rv, input logic [31:0] rpc);
    start              = st;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Pulse start for one edge; returns just after the sampling edge.
  task automatic startRun(input logic rdy);
    applyStimulus(1'b1, rdy, 1'b0, 32'h0);
    tick();
    start = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head entry must match the next
  // expected PC and the memory word at that PC.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        $display("[TB] FAIL sb_unexpected: got pc %h, expected no transfer", bus.out_pc);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        checkOutput("sb_pc", bus.out_pc, e);
        checkOutput("sb_instr", bus.out_instr, expInstr(e));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'hC0DE_0000 + i;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    #2;

    // Reset values
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_pc", bus.out_pc, 32'h0);
    checkOutput("rst_out_instr", bus.out_instr, 32'h0);
    checkOutput("rst_fault", {31'b0, fault}, 32'd0);
    checkOutput("rst_fault_pc", fault_pc, 32'h0);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
    doReset();

    // Streaming with out_ready held high: four back-to-back transfers
    for (int i = 0; i < 4; i++) expq.push_back(32'(i * 4));
    startRun(1'b1);
    repeat (5) tick();
    bus.out_ready = 1'b0;
    checkOutput("t1_delivered", 32'(expq.size()), 32'd0);

    // Back-pressure: two entries buffered, PC held at 0x8
    doReset();
    startRun(1'b0);
    repeat (5) tick();
    checkOutput("t2_imem_addr", bus.imem_addr, 32'h8);
    checkOutput("t2_out_pc", bus.out_pc, 32'h0);
    expq.push_back(32'h0);
    expq.push_back(32'h4);
    expq.push_back(32'h8);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    checkOutput("t2_delivered", 32'(expq.size()), 32'd0);

    // Redirect with 0x18/0x1C buffered and 0x18 popped in the same cycle
    doReset();
    for (int i = 0; i < 6; i++) expq.push_back(32'(i * 4));
    startRun(1'b1);
    repeat (7) tick();
    bus.out_ready = 1'b0;
    repeat (2) tick();
    checkOutput("t3_head_pc", bus.out_pc, 32'h18);
    checkOutput("t3_imem_addr", bus.imem_addr, 32'h20);
    expq.push_back(32'h18);
    expq.push_back(32'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
    tick();
    bus.redirect_valid = 1'b0;
    checkOutput("t3_bubble", {31'b0, bus.out_valid}, 32'd0);
    tick();
    checkOutput("t3_target_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("t3_target_pc", bus.out_pc, 32'h40);
    tick();
    bus.out_ready = 1'b0;
    checkOutput("t3_delivered", 32'(expq.size()), 32'd0);

    // Misaligned redirect traps; legal redirect recovers
    doReset();
    startRun(1'b0);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h42);
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    checkOutput("t4_fault", {31'b0, fault}, 32'd1);
    checkOutput("t4_fault_pc", fault_pc, 32'h42);
    checkOutput("t4_flushed", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("t4_no_push", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("t4_pc_held", bus.imem_addr, 32'h42);
    expq.push_back(32'h2C);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h2C);
    tick();
    bus.redirect_valid = 1'b0;
    checkOutput("t4_fault_clr", {31'b0, fault}, 32'd0);
    checkOutput("t4_resume_addr", bus.imem_addr, 32'h2C);
    repeat (2) tick();
    bus.out_ready = 1'b0;
    checkOutput("t4_delivered", 32'(expq.size()), 32'd0);

    // Run off the end of memory
    doReset();
    for (int i = 0; i < 256; i++) expq.push_back(32'(i * 4));
    startRun(1'b1);
    for (int i = 0; i < 400 && expq.size() != 0; i++) tick();
    checkOutput("t5_drained", 32'(expq.size()), 32'd0);
    expq.delete();
    repeat (3) tick();
    checkOutput("t5_fault", {31'b0, fault}, 32'd1);
    checkOutput("t5_fault_pc", fault_pc, 32'h400);
    checkOutput("t5_empty", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-stream with two entries buffered
    doReset();
    startRun(1'b0);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (3) tick();
    checkOutput("t6_pre_pc", bus.out_pc, 32'h100);
    checkOutput("t6_pre_instr", bus.out_instr, expInstr(32'h100));
    checkOutput("t6_pre_addr", bus.imem_addr, 32'h108);
    rst = 1'b1;
    #1;
    checkOutput("t6_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("t6_out_pc", bus.out_pc, 32'h0);
    checkOutput("t6_out_instr", bus.out_instr, 32'h0);
    checkOutput("t6_imem_addr", bus.imem_addr, 32'h0);
    checkOutput("t6_fault", {31'b0, fault}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    expq.push_back(32'h0);
    expq.push_back(32'h4);
    startRun(1'b1);
    repeat (3) tick();
    bus.out_ready = 1'b0;
    checkOutput("t6_restart", 32'(expq.size()), 32'd0);

    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
